// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_ctrl_pkg;

    localparam int SAC_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sac_state_e;

    // Counter must reach WIDTH-1 without wrapping; a one-bit operand still needs one bit.
    function automatic int sac_cnt_width(input int width);
        if (width > 1) begin
            return $clog2(width);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
import serial_adder_ctrl_pkg::*;

interface serial_adder_ctrl_if #(
    parameter int WIDTH = SAC_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;

    modport master (
        output start, a_in, b_in, cin,
        input  ready, busy, done, sum_out, cout
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output ready, busy, done, sum_out, cout
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one operand bit pair per SHIFT cycle through a single full
// adder, result published on the SHIFT->DONE edge and held until the next one.
import serial_adder_ctrl_pkg::*;

module serial_adder_ctrl #(
    parameter int WIDTH = SAC_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int             CNT_W    = sac_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sac_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_sum_s;
    logic             fa_carry_s;
    logic [WIDTH-1:0] sh_next_s;

    full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (carry_q),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    // Sum shift register after inserting this cycle's bit at the MSB.
    always_comb begin
        sh_next_s            = sh_q >> 1;
        sh_next_s[WIDTH-1]   = fa_sum_s;
    end

    // Next-state and datapath update for the three-state controller.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    carry_d = bus.cin;
                    sh_d    = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sh_d    = sh_next_s;
                carry_d = fa_carry_s;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = sh_next_s;
                    cout_d  = fa_carry_s;
                end else begin
                    state_d = SHIFT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset clearing everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = (state_q == DONE);
    assign bus.sum_out = sum_q;
    assign bus.cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for done on the 8-bit DUT; n is the cycle index (acceptance cycle = 0).
    task automatic wait_done8(inout int n);
        while (bus8.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] es, input logic ec);
        int n;
        bus8.a_in  = a;
        bus8.b_in  = b;
        bus8.cin   = c;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        n = 1;
        check_eq({tag, "_busy"}, bus8.busy, 1'b1);
        check_eq({tag, "_ready"}, bus8.ready, 1'b0);
        wait_done8(n);
        check_eq({tag, "_lat"}, n, 9);
        check_eq({tag, "_sum"}, bus8.sum_out, es);
        check_eq({tag, "_cout"}, bus8.cout, ec);
        tick();
        check_eq({tag, "_idle"}, bus8.ready, 1'b1);
        check_eq({tag, "_donelow"}, bus8.done, 1'b0);
    endtask

    initial begin
        int n;
        int k;
        logic seen_done;
        logic [1:0] exp1;

        rst = 1'b1;
        bus8.start = 1'b0; bus8.a_in = 8'h00; bus8.b_in = 8'h00; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a_in = 1'b0;  bus1.b_in = 1'b0;  bus1.cin = 1'b0;
        tick();
        tick();
        check_eq("rst_ready", bus8.ready, 1'b1);
        check_eq("rst_busy", bus8.busy, 1'b0);
        check_eq("rst_done", bus8.done, 1'b0);
        check_eq("rst_sum", bus8.sum_out, 8'h00);
        check_eq("rst_cout", bus8.cout, 1'b0);

        // start while in reset must not be accepted
        bus8.start = 1'b1;
        tick();
        check_eq("rst_ovr_ready", bus8.ready, 1'b1);
        check_eq("rst_ovr_busy", bus8.busy, 1'b0);
        rst = 1'b0;

        op8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op8("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        op8("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        op8("7f_01", 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0);
        op8("ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        op8("7f_01b", 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0);

        // start pulsed mid-operation is ignored; prior result held until DONE
        bus8.a_in = 8'h12; bus8.b_in = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        n = 1;
        tick(); n++;
        bus8.a_in = 8'hFF; bus8.b_in = 8'hFF; bus8.cin = 1'b1; bus8.start = 1'b1;
        tick(); n++;
        bus8.start = 1'b0;
        check_eq("ign_hold_sum", bus8.sum_out, 8'h81);
        check_eq("ign_hold_cout", bus8.cout, 1'b0);
        check_eq("ign_busy", bus8.busy, 1'b1);
        wait_done8(n);
        check_eq("ign_lat", n, 9);
        check_eq("ign_sum", bus8.sum_out, 8'h46);
        check_eq("ign_cout", bus8.cout, 1'b0);
        tick();

        // reset in the 4th SHIFT cycle aborts without a done pulse
        bus8.a_in = 8'hFF; bus8.b_in = 8'hFF; bus8.cin = 1'b1; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("abort_busy4", bus8.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_ready", bus8.ready, 1'b1);
        check_eq("abort_busy", bus8.busy, 1'b0);
        check_eq("abort_done", bus8.done, 1'b0);
        check_eq("abort_sum", bus8.sum_out, 8'h00);
        check_eq("abort_cout", bus8.cout, 1'b0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen_done = seen_done | bus8.done;
        end
        check_eq("abort_nodone", seen_done, 1'b0);

        // start held high: two operations, done pulses WIDTH+2 apart
        bus8.a_in = 8'h12; bus8.b_in = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
        tick();
        n = 1;
        wait_done8(n);
        check_eq("b2b_lat", n, 9);
        check_eq("b2b_sum1", bus8.sum_out, 8'h46);
        check_eq("b2b_cout1", bus8.cout, 1'b0);
        bus8.a_in = 8'hA5; bus8.b_in = 8'h5A; bus8.cin = 1'b1;
        k = 0;
        tick(); k++;
        while (bus8.done !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        bus8.start = 1'b0;
        check_eq("b2b_space", k, 10);
        check_eq("b2b_sum2", bus8.sum_out, 8'h00);
        check_eq("b2b_cout2", bus8.cout, 1'b1);
        tick();

        // WIDTH=1: full-adder truth table, done two cycles after acceptance
        for (int i = 0; i < 8; i++) begin
            bus1.a_in  = i[2];
            bus1.b_in  = i[1];
            bus1.cin   = i[0];
            exp1       = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            bus1.start = 1'b1;
            tick();
            bus1.start = 1'b0;
            n = 1;
            while (bus1.done !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check_eq($sformatf("w1_lat_%0d", i), n, 2);
            check_eq($sformatf("w1_res_%0d", i), {bus1.cout, bus1.sum_out}, exp1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
